// File: rtl/mem_initiator.sv
// rtl/mem_initiator.sv - data-side load/store initiator driving the unified cache data port
// Optional miss timeout (fault 11) is compiled in with MEM_INITIATOR_TIMEOUT_EN.
module mem_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_wr,
  input  logic [1:0]  i_cmd_size,
  input  logic        i_cmd_signed,
  input  logic [31:0] i_cmd_addr,
  input  logic [31:0] i_cmd_wdata,
  output logic [31:0] o_address,
  output logic [31:0] o_data,
  output logic [3:0]  o_ben,
  output logic        o_rd_en,
  output logic        o_wr_en,
  input  logic [31:0] i_data,
  input  logic        i_miss,
  input  logic        i_abort,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic [1:0]  o_rsp_fault
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] FLT_OK      = 2'd0;
  localparam logic [1:0] FLT_ABORT   = 2'd1;
  localparam logic [1:0] FLT_ILLEGAL = 2'd2;
  localparam logic [1:0] FLT_TIMEOUT = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  ben_q, ben_d;
  logic        rd_en_q, rd_en_d;
  logic        wr_en_q, wr_en_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_fault_q, rsp_fault_d;

  logic        cmd_illegal;
  logic [3:0]  cmd_ben;
  logic [31:0] cmd_data;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;
  logic        timeout_hit;

  always_comb begin
    cmd_illegal = 1'b0;
    cmd_ben     = 4'b1111;
    cmd_data    = i_cmd_wdata;
    case (i_cmd_size)
      SZ_BYTE: begin
        cmd_ben  = 4'b0001 << i_cmd_addr[1:0];
        cmd_data = {4{i_cmd_wdata[7:0]}};
      end
      SZ_HALF: begin
        cmd_illegal = i_cmd_addr[0];
        cmd_ben     = i_cmd_addr[1] ? 4'b1100 : 4'b0011;
        cmd_data    = {2{i_cmd_wdata[15:0]}};
      end
      SZ_WORD: cmd_illegal = (i_cmd_addr[1:0] != 2'b00);
      default: cmd_illegal = 1'b1;
    endcase
  end

  // Lane selection uses the registered address so capture matches the held request.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_b = i_data[7:0];
      2'd1:    lane_b = i_data[15:8];
      2'd2:    lane_b = i_data[23:16];
      default: lane_b = i_data[31:24];
    endcase
    lane_h = addr_q[1] ? i_data[31:16] : i_data[15:0];
    case (size_q)
      SZ_BYTE: load_data = {{24{signed_q & lane_b[7]}}, lane_b};
      SZ_HALF: load_data = {{16{signed_q & lane_h[15]}}, lane_h};
      default: load_data = i_data;
    endcase
  end

`ifdef MEM_INITIATOR_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_hit = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (state_q == ST_REQ && i_miss && !i_abort && !timeout_hit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    ben_d       = ben_q;
    rd_en_d     = rd_en_q;
    wr_en_d     = wr_en_q;
    size_d      = size_q;
    signed_d    = signed_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_fault_d = rsp_fault_q;
    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          addr_d      = i_cmd_addr;
          size_d      = i_cmd_size;
          signed_d    = i_cmd_signed;
          rsp_rdata_d = '0;
          if (cmd_illegal) begin
            state_d     = ST_RSP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = FLT_ILLEGAL;
          end else begin
            state_d = ST_REQ;
            ben_d   = cmd_ben;
            data_d  = cmd_data;
            rd_en_d = !i_cmd_wr;
            wr_en_d = i_cmd_wr;
          end
        end
      end
      ST_REQ: begin
        if (i_abort || !i_miss || timeout_hit) begin
          state_d     = ST_RSP;
          rsp_valid_d = 1'b1;
          ben_d       = '0;
          rd_en_d     = 1'b0;
          wr_en_d     = 1'b0;
          rsp_rdata_d = '0;
          if (i_abort) begin
            rsp_fault_d = FLT_ABORT;
          end else if (!i_miss) begin
            rsp_fault_d = FLT_OK;
            if (rd_en_q) begin
              rsp_rdata_d = load_data;
            end
          end else begin
            rsp_fault_d = FLT_TIMEOUT;
          end
        end
      end
      ST_RSP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      ben_q       <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      size_q      <= SZ_BYTE;
      signed_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= FLT_OK;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      ben_q       <= ben_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign o_cmd_ready = (state_q == ST_IDLE);
  assign o_address   = {addr_q[31:2], 2'b00};
  assign o_data      = data_q;
  assign o_ben       = ben_q;
  assign o_rd_en     = rd_en_q;
  assign o_wr_en     = wr_en_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_mem_initiator.sv
// tb/tb_mem_initiator.sv - directed and randomized bench for mem_initiator
// Set MEM_INITIATOR_TIMEOUT_EN to exercise the timeout build with TIMEOUT_CYCLES = 4.
module tb_mem_initiator;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [1:0]  cmd_size;
  logic        cmd_signed;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [31:0] address;
  logic [31:0] wdata_bus;
  logic [3:0]  ben;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] rdata_bus;
  logic        miss;
  logic        abort;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_fault;

  int checks = 0;
  int failures = 0;

`ifdef MEM_INITIATOR_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 4;
`else
  localparam int unsigned TB_TIMEOUT = 64;
`endif

  mem_initiator #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_wr     (cmd_wr),
    .i_cmd_size   (cmd_size),
    .i_cmd_signed (cmd_signed),
    .i_cmd_addr   (cmd_addr),
    .i_cmd_wdata  (cmd_wdata),
    .o_address    (address),
    .o_data       (wdata_bus),
    .o_ben        (ben),
    .o_rd_en      (rd_en),
    .o_wr_en      (wr_en),
    .i_data       (rdata_bus),
    .i_miss       (miss),
    .i_abort      (abort),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_rdata  (rsp_rdata),
    .o_rsp_fault  (rsp_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one command starting at a negedge with the DUT idle; ends at a negedge with the DUT idle.
  task automatic do_cmd(input string tag, input logic wr, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] idata,
                        input int miss_edges, input int abort_edge);
    int          nbytes;
    int          off;
    longint      mask;
    longint      val;
    bit          illegal;
    bit          aborted;
    int          stop_edge;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic [3:0]  e_ben;
    logic [31:0] e_rdata;
    nbytes  = (size == 2'd3) ? 0 : (1 << size);
    off     = addr % 4;
    illegal = (nbytes == 0) || ((addr % nbytes) != 0);
    e_addr  = addr - off;
    e_ben   = 4'(((1 << nbytes) - 1) << off);
    if (nbytes == 1) e_data = (wdata % 256) * 32'h0101_0101;
    else if (nbytes == 2) e_data = (wdata % 65536) * 32'h0001_0001;
    else e_data = wdata;
    mask = (64'd1 << (8 * nbytes)) - 1;
    val  = (longint'(idata) >> (8 * off)) & mask;
    if (sgn && nbytes < 4 && val >= (mask + 1) / 2) val = val - (mask + 1);
    e_rdata = 32'(val);

    chk({tag, ".ready"}, {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_size = size; cmd_signed = sgn;
    cmd_addr = addr; cmd_wdata = wdata; rdata_bus = idata; miss = 1'b0; abort = 1'b0;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    if (illegal) begin
      chk({tag, ".ill_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, ".ill_fault"}, {30'd0, rsp_fault}, 32'd2);
      chk({tag, ".ill_rdata"}, rsp_rdata, 32'd0);
      chk({tag, ".ill_en"}, {30'd0, rd_en, wr_en}, 32'd0);
    end else begin
      aborted   = (abort_edge >= 0) && (abort_edge <= miss_edges);
      stop_edge = aborted ? abort_edge : miss_edges;
      for (int e = 0; e <= stop_edge; e++) begin
        chk({tag, ".addr"}, address, e_addr);
        chk({tag, ".ben"}, {28'd0, ben}, {28'd0, e_ben});
        chk({tag, ".en"}, {30'd0, rd_en, wr_en}, {30'd0, !wr, wr});
        if (wr) chk({tag, ".data"}, wdata_bus, e_data);
        chk({tag, ".no_rsp"}, {31'd0, rsp_valid}, 32'd0);
        miss  = (e < miss_edges);
        abort = (e == abort_edge);
        @(posedge clk); @(negedge clk);
      end
      miss = 1'b0; abort = 1'b0;
      chk({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, ".rsp_fault"}, {30'd0, rsp_fault}, aborted ? 32'd1 : 32'd0);
      chk({tag, ".rsp_rdata"}, rsp_rdata, (wr || aborted) ? 32'd0 : e_rdata);
      chk({tag, ".rsp_bus_idle"}, {27'd0, ben, rd_en, wr_en}, 32'd0);
    end
    @(posedge clk); @(negedge clk);
    chk({tag, ".pulse_end"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, ".ready_again"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_size = 2'd0; cmd_signed = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; rdata_bus = '0; miss = 1'b0; abort = 1'b0;
    #2;
    chk("reset.ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset.outs", address | wdata_bus | rsp_rdata, 32'd0);
    chk("reset.ctl", {25'd0, ben, rd_en, wr_en, rsp_valid}, 32'd0);
    chk("reset.fault", {30'd0, rsp_fault}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_cmd("word_ld", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, -1);
    do_cmd("sbyte_ld", 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF_0000, 0, -1);
    do_cmd("ubyte_ld", 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF_0000, 0, -1);
    do_cmd("half_st", 1'b1, 2'd1, 1'b0, 32'h202, 32'h1234_ABCD, 32'h0, 5, -1);
    do_cmd("mis_word", 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h0, 0, -1);
    do_cmd("rsv_size", 1'b1, 2'd3, 1'b0, 32'h40, 32'h5, 32'h0, 0, -1);
    do_cmd("abort_miss", 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h1111_2222, 1, 0);
    do_cmd("shalf_ld", 1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 32'h9ABC_0000, 2, -1);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      int          m;
      int          ab;
      sz = 2'($urandom_range(0, 3));
      a  = ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) a = a & ~((32'd1 << sz) - 1);
      m  = $urandom_range(0, 3);
      ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, m) : -1;
      do_cmd($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             a, $urandom(), $urandom(), m, ab);
    end

    // Reset while a missed load is pending.
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_size = 2'd2; cmd_addr = 32'h500; miss = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst_mid.req", {31'd0, rd_en}, 32'd1);
    @(posedge clk); @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid.outs", address | wdata_bus | rsp_rdata, 32'd0);
    chk("rst_mid.ctl", {25'd0, ben, rd_en, wr_en, rsp_valid}, 32'd0);
    chk("rst_mid.ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    chk("rst_mid.no_rsp", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0; miss = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_mid.no_replay", {30'd0, rd_en, rsp_valid}, 32'd0);
    do_cmd("after_rst", 1'b0, 2'd0, 1'b1, 32'h501, 32'h0, 32'h0000_7F00, 0, -1);

    // Miss stuck high.
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_size = 2'd2; cmd_addr = 32'h600; miss = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    pulses = 0;
`ifdef MEM_INITIATOR_TIMEOUT_EN
    for (int e = 1; e < int'(TB_TIMEOUT); e++) begin
      @(posedge clk); @(negedge clk);
      if (rsp_valid) pulses++;
    end
    chk("timeout.early", pulses, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("timeout.valid", {31'd0, rsp_valid}, 32'd1);
    chk("timeout.fault", {30'd0, rsp_fault}, 32'd3);
    chk("timeout.rdata", rsp_rdata, 32'd0);
    miss = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("timeout.ready", {31'd0, cmd_ready}, 32'd1);
`else
    for (int e = 0; e < 100; e++) begin
      @(posedge clk); @(negedge clk);
      if (rsp_valid) pulses++;
    end
    chk("no_timeout.pulses", pulses, 32'd0);
    chk("no_timeout.held", {31'd0, rd_en}, 32'd1);
    miss = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("no_timeout.done", {30'd0, rsp_valid, rsp_fault[0]}, 32'd2);
    @(posedge clk); @(negedge clk);
`endif
    do_cmd("final", 1'b1, 2'd0, 1'b0, 32'h7, 32'hA5, 32'h0, 1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_initiator.md
# mem_initiator

Data-side memory request initiator that drives the unified cache's data port: address, write data, byte enables, read and write enables. It accepts one load/store command at a time from a core-side or bench-side client. It performs lane steering and byte-enable generation, and holds the request stable while the cache signals a miss. It returns sign- or zero-extended read data with a fault code.

## Interface
- TIMEOUT_CYCLES, 64: consecutive miss cycles tolerated before a timeout fault. Only used when the timeout feature is compiled in. Must be ≥ 2.

- i_clk  in  1  clock; all state changes on the rising edge
- i_reset  in  1  reset, asynchronous, active-high
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  command accepted when valid && ready at a rising edge
- i_cmd_wr  in  1  1 = store, 0 = load
- i_cmd_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- i_cmd_signed  in  1  sign-extend load result
- i_cmd_addr  in  32  byte address
- i_cmd_wdata  in  32  store data, right-aligned
- o_address  out  32  word-aligned address to the cache: {addr[31:2],2'b00}
- o_data  out  32  lane-replicated store data
- o_ben  out  4  byte enables; bit n covers byte n
- o_rd_en  out  1  read request
- o_wr_en  out  1  write request
- i_data  in  32  cache read data, combinational from o_address
- i_miss  in  1  cache not ready; sampled at the rising edge
- i_abort  in  1  data abort; sampled at the rising edge
- o_rsp_valid  out  1  one-cycle response pulse
- o_rsp_rdata  out  32  extended load data; 0 for stores and faults
- o_rsp_fault  out  2  00 ok, 01 abort, 10 misaligned/illegal, 11 timeout

## Operation
- States: IDLE, REQ, RSP. o_cmd_ready = (state == IDLE), combinational.
- IDLE, on accept, performs a legality check:
  - Illegal commands: size 11, halfword with addr[0] = 1, or word with addr[1:0] ≠ 0.
  - Illegal command → RSP with fault 10. No bus access: rd/wr enables stay 0.
  - Legal command → register the bus outputs and go to REQ.
- Byte enables and store data:
  - byte: ben = 1 << addr[1:0]; o_data = {4{wdata[7:0]}}
  - halfword: ben = addr[1] ? 1100 : 0011; o_data = {2{wdata[15:0]}}
  - word: ben = 1111; o_data = wdata
  - Loads drive the same ben pattern, o_rd_en = 1, o_wr_en = 0. Stores drive o_wr_en = 1, o_rd_en = 0.
- REQ: all bus outputs are held constant. At each rising edge:
  - i_abort = 1 → RSP, fault 01. Abort has priority over miss.
  - else i_miss = 0 → capture and go to RSP, fault 00.
  - else stay in REQ.
- Load capture:
  - Byte = i_data[8*addr[1:0] +: 8].
  - Halfword = i_data[16*addr[1] +: 16].
  - Word = i_data.
  - Sign-extend if i_cmd_signed, otherwise zero-extend.
  - The signed flag is ignored for word loads.
- RSP: o_rsp_valid = 1 for exactly one cycle. Bus enables and ben are 0. Next state is IDLE.
- A new command can be accepted at the earliest in the cycle after RSP.

## Timing
- Reset values:
  - o_cmd_ready 1 (state IDLE).
  - o_address, o_data, o_rsp_rdata: 0.
  - o_ben 0; o_rd_en, o_wr_en 0.
  - o_rsp_valid 0; o_rsp_fault 00.
  - Wait counter 0.
- Reset mid-operation: the request is dropped immediately and asynchronously. No response pulse is issued and the request is not replayed after reset.
- Accept at edge N → bus request visible from N+ε.
- Earliest completion: edge N+1 (miss low) → o_rsp_valid high in cycle N+1..N+2 → ready again at N+2. Minimum command-to-command spacing is 3 cycles.
- Each miss cycle adds exactly one cycle of latency.
- Illegal command: accepted at N, rsp_valid in cycle N..N+1.
- Store data is written by the cache at the completing edge. Stores repeated during miss cycles are idempotent because the outputs are held.

## Configuration
- MEM_INITIATOR_TIMEOUT_EN:
  - Defined: a $clog2(TIMEOUT_CYCLES)-bit counter clears on entry to REQ and increments on each REQ edge with i_miss = 1 and i_abort = 0. At an edge where the counter equals TIMEOUT_CYCLES-1 and i_miss = 1 → RSP, fault 11, rdata 0.
  - Undefined: no counter; REQ waits indefinitely and fault 11 is never produced.

## Test plan
- Word load, addr 0x100, i_data = 0xDEADBEEF, miss low → ben 1111, rsp_rdata 0xDEADBEEF, fault 00, rsp_valid at cycle 1 after accept.
- Signed byte load at addr 0x103 with i_data = 0x80FF0000 → ben 1000, rsp_rdata 0xFFFFFF80. Unsigned version → 0x00000080.
- Halfword store, addr 0x202, wdata 0x1234ABCD, miss high for 5 edges → o_data 0xABCDABCD, ben 1100, wr_en held 6 cycles, rsp_valid at cycle 6.
- Word load at 0x101 → fault 10, rd_en never asserted. Load with i_abort = 1 and miss = 1 together → fault 01.
- Reset asserted during REQ with miss high → all outputs 0 asynchronously, no rsp_valid; next command completes normally.
- With MEM_INITIATOR_TIMEOUT_EN, TIMEOUT_CYCLES = 4, miss stuck high → fault 11 at the 4th REQ edge. Without the macro → no response after 100 cycles.
